board_fetch_arbiter: RTL and testbench

//  Shares the single-port board RAM between the CPU load/store path and the VGA renderer.

---
 rtl/board_fetch_arbiter_if.sv | 30 +++
 rtl/board_fetch_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_board_fetch_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/board_fetch_arbiter_if.sv
// Bus bundle for board_fetch_arbiter: CPU load/store path, board RAM port,
// row prefetch handshake and renderer line-buffer read port.
interface board_fetch_arbiter_if #(
   parameter int ADDR_W  = 12,
   parameter int COLOR_W = 3
);
   logic               cpu_req;
   logic [ADDR_W-1:0]  cpu_addr;
   logic               cpu_stall;
   logic [ADDR_W-1:0]  ram_addr;
   logic [COLOR_W-1:0] ram_q;
   logic               row_req;
   logic [4:0]         row_idx;
   logic               row_busy;
   logic               row_done;
   logic               swap;
   logic [3:0]         rd_col;
   logic [COLOR_W-1:0] rd_color;
   logic               overrun;

   modport master (
      output cpu_req, cpu_addr, ram_q, row_req, row_idx, swap, rd_col,
      input  cpu_stall, ram_addr, row_busy, row_done, rd_color, overrun
   );

   modport slave (
      input  cpu_req, cpu_addr, ram_q, row_req, row_idx, swap, rd_col,
      output cpu_stall, ram_addr, row_busy, row_done, rd_color, overrun
   );
endinterface

// File: rtl/board_fetch_arbiter.sv
// Shares the board RAM between CPU load/store and a row prefetch into a
// double-buffered line buffer that the VGA renderer reads from.
module board_fetch_arbiter #(
   parameter int COLS         = 10,
   parameter int ROWS         = 20,
   parameter int BASE_ADDR    = 0,
   parameter int ADDR_W       = 12,
   parameter int COLOR_W      = 3,
   parameter int STARVE_LIMIT = 8
) (
   input logic                   clock,
   input logic                   reset_n,
   board_fetch_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int                SW        = 16;
   localparam logic [4:0]        ROWS_L    = 5'(ROWS);
   localparam logic [3:0]        LAST_COL  = 4'(COLS - 1);
   localparam logic [3:0]        COLS_L    = 4'(COLS);
   localparam logic [SW-1:0]     STARVE_L  = SW'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0] BASE_L    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

   state_t              state_q, state_d;
   logic [4:0]          row_idx_q, row_idx_d;
   logic                oor_q, oor_d;
   logic [3:0]          issue_col_q, issue_col_d;
   logic [SW-1:0]       starve_cnt_q, starve_cnt_d;
   logic                cap_vld_q, cap_vld_d;
   logic [3:0]          cap_col_q, cap_col_d;
   logic                front_q, front_d;
   logic [COLOR_W-1:0]  bank_q [2][COLS];
   logic [COLOR_W-1:0]  bank_d [2][COLS];
   logic                overrun_q, overrun_d;
   logic                row_busy_q, row_busy_d;
   logic                row_done_q, row_done_d;

   logic                forced_s;
   logic                disp_gnt_s;
   logic                back_s;
   logic [ADDR_W-1:0]   disp_addr_s;

   // Grant decision and RAM address mux; the display only competes during FETCH.
   always_comb begin
      forced_s    = (STARVE_LIMIT != 32'sd0) && (starve_cnt_q == STARVE_L);
      disp_gnt_s  = (state_q == S_FETCH) && !oor_q && (!bus.cpu_req || forced_s);
      back_s      = ~front_q;
      disp_addr_s = BASE_L + COLS_A * ADDR_W'(row_idx_q) + ADDR_W'(issue_col_q);
      if (disp_gnt_s) begin
         bus.ram_addr = disp_addr_s;
      end else begin
         bus.ram_addr = bus.cpu_addr;
      end
      bus.cpu_stall = disp_gnt_s && bus.cpu_req;
   end

   // Renderer read port: front bank only, zero beyond the row width.
   always_comb begin
      if (bus.rd_col < COLS_L) begin
         bus.rd_color = bank_q[front_q][bus.rd_col];
      end else begin
         bus.rd_color = '0;
      end
   end

   // Next-state logic for the fetch sequencer, line buffer and status flags.
   always_comb begin
      state_d      = state_q;
      row_idx_d    = row_idx_q;
      oor_d        = oor_q;
      issue_col_d  = issue_col_q;
      bank_d       = bank_q;
      cap_vld_d    = disp_gnt_s;
      cap_col_d    = issue_col_q;

      // A capture issued last cycle lands even if the CPU owns the port now.
      if (cap_vld_q) begin
         bank_d[back_s][cap_col_q] = bus.ram_q;
      end else begin
         bank_d[back_s][0] = bank_q[back_s][0];
      end

      if ((state_q != S_FETCH) || disp_gnt_s) begin
         starve_cnt_d = '0;
      end else if (bus.cpu_req) begin
         starve_cnt_d = starve_cnt_q + 16'd1;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end

      if (bus.swap && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
         front_d = ~front_q;
      end else begin
         front_d = front_q;
      end

      overrun_d = overrun_q
                | (bus.row_req && (state_q != S_IDLE))
                | (bus.swap && ((state_q == S_FETCH) || (state_q == S_DRAIN)));

      case (state_q)
         S_IDLE: begin
            if (bus.row_req) begin
               row_idx_d   = bus.row_idx;
               oor_d       = (bus.row_idx >= ROWS_L);
               issue_col_d = 4'd0;
               state_d     = S_FETCH;
            end else begin
               state_d     = S_IDLE;
            end
         end
         S_FETCH: begin
            if (oor_q) begin
               for (int i = 0; i < COLS; i++) begin
                  bank_d[back_s][i] = '0;
               end
               state_d = S_DONE;
            end else if (disp_gnt_s) begin
               issue_col_d = issue_col_q + 4'd1;
               if (issue_col_q == LAST_COL) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      row_busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
      row_done_d = (state_d == S_DONE);
   end

   // State and line-buffer registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         row_idx_q    <= 5'd0;
         oor_q        <= 1'b0;
         issue_col_q  <= 4'd0;
         starve_cnt_q <= '0;
         cap_vld_q    <= 1'b0;
         cap_col_q    <= 4'd0;
         front_q      <= 1'b0;
         overrun_q    <= 1'b0;
         row_busy_q   <= 1'b0;
         row_done_q   <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < COLS; i++) begin
               bank_q[b][i] <= '0;
            end
         end
      end else begin
         state_q      <= state_d;
         row_idx_q    <= row_idx_d;
         oor_q        <= oor_d;
         issue_col_q  <= issue_col_d;
         starve_cnt_q <= starve_cnt_d;
         cap_vld_q    <= cap_vld_d;
         cap_col_q    <= cap_col_d;
         front_q      <= front_d;
         overrun_q    <= overrun_d;
         row_busy_q   <= row_busy_d;
         row_done_q   <= row_done_d;
         bank_q       <= bank_d;
      end
   end

   assign bus.row_busy = row_busy_q;
   assign bus.row_done = row_done_q;
   assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_board_fetch_arbiter.sv
// Directed bench for board_fetch_arbiter: two instances (STARVE_LIMIT 8 and 0)
// share stimulus; a small RAM model per instance supplies registered read data.
module tb_board_fetch_arbiter;
   typedef struct {
      logic [3:0] col;
      logic [2:0] exp;
   } rd_vec_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        cpu_req;
   logic [11:0] cpu_addr;
   logic        row_req;
   logic [4:0]  row_idx;
   logic        swap;
   logic [3:0]  rd_col;
   logic [2:0]  ram_q_a, ram_q_b;
   logic [2:0]  mem [0:4095];
   logic        sel_b;
   int          checks = 0;
   int          failures = 0;
   rd_vec_t     vec [16];

   logic        stall_o, busy_o, done_o, ovr_o;
   logic [11:0] addr_o;
   logic [2:0]  color_o;

   always #5 clock = ~clock;

   board_fetch_arbiter_if #(.ADDR_W(12), .COLOR_W(3)) if_a ();
   board_fetch_arbiter_if #(.ADDR_W(12), .COLOR_W(3)) if_b ();

   assign if_a.cpu_req  = cpu_req;   assign if_b.cpu_req  = cpu_req;
   assign if_a.cpu_addr = cpu_addr;  assign if_b.cpu_addr = cpu_addr;
   assign if_a.row_req  = row_req;   assign if_b.row_req  = row_req;
   assign if_a.row_idx  = row_idx;   assign if_b.row_idx  = row_idx;
   assign if_a.swap     = swap;      assign if_b.swap     = swap;
   assign if_a.rd_col   = rd_col;    assign if_b.rd_col   = rd_col;
   assign if_a.ram_q    = ram_q_a;   assign if_b.ram_q    = ram_q_b;

   board_fetch_arbiter #(.STARVE_LIMIT(8)) dut_a (.clock(clock), .reset_n(reset_n), .bus(if_a));
   board_fetch_arbiter #(.STARVE_LIMIT(0)) dut_b (.clock(clock), .reset_n(reset_n), .bus(if_b));

   always @(posedge clock) begin
      ram_q_a <= mem[if_a.ram_addr];
      ram_q_b <= mem[if_b.ram_addr];
   end

   always_comb begin
      stall_o = sel_b ? if_b.cpu_stall : if_a.cpu_stall;
      busy_o  = sel_b ? if_b.row_busy  : if_a.row_busy;
      done_o  = sel_b ? if_b.row_done  : if_a.row_done;
      ovr_o   = sel_b ? if_b.overrun   : if_a.overrun;
      addr_o  = sel_b ? if_b.ram_addr  : if_a.ram_addr;
      color_o = sel_b ? if_b.rd_color  : if_a.rd_color;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_swap();
      swap = 1'b1;
      tick();
      swap = 1'b0;
   endtask

   task automatic readback_vec(input string name);
      for (int i = 0; i < 16; i++) begin
         rd_col = vec[i].col;
         @(negedge clock);
         chk(name, {29'd0, color_o}, {29'd0, vec[i].exp});
         tick();
      end
   endtask

   task automatic readback_mem(input string name, input int base, input bit zeros);
      logic [2:0] e;
      for (int i = 0; i < 11; i++) begin
         rd_col = 4'(i);
         e = (zeros || i >= 10) ? 3'd0 : mem[base + i];
         @(negedge clock);
         chk(name, {29'd0, color_o}, {29'd0, e});
         tick();
      end
   endtask

   // CPU idle fetch; inject adds a row_req in FETCH, swap in DRAIN and swap in DONE.
   task automatic fetch_idle(input int row, input int base, input bit inject);
      cpu_req  = 1'b0;
      cpu_addr = 12'hFFF;
      row_req  = 1'b1;
      row_idx  = 5'(row);
      tick();
      row_req  = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         row_req = inject && (c == 4);
         row_idx = (inject && c == 4) ? 5'd9 : 5'(row);
         swap    = inject && (c == 11 || c == 12);
         @(negedge clock);
         chk("fetch_addr", {20'd0, addr_o}, (c <= 10) ? 32'(base + c - 1) : 32'h0FFF);
         chk("fetch_busy", {31'd0, busy_o}, {31'd0, (c <= 11)});
         chk("fetch_done", {31'd0, done_o}, {31'd0, (c == 12)});
         chk("fetch_stall", {31'd0, stall_o}, 32'd0);
         chk("fetch_overrun", {31'd0, ovr_o}, {31'd0, (inject && c >= 5)});
         tick();
      end
      row_req = 1'b0;
      swap    = 1'b0;
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) mem[a] = 3'((a * 3 + 1) % 8);
      for (int i = 0; i < 16; i++) begin
         vec[i].col = 4'(i);
         vec[i].exp = (i < 7) ? 3'(i + 1) : (i < 10) ? 3'(i - 6) : 3'd0;
      end
      for (int i = 0; i < 10; i++) mem[30 + i] = vec[i].exp;

      sel_b    = 1'b0;
      reset_n  = 1'b0;
      cpu_req  = 1'b0;
      cpu_addr = 12'h0AA;
      row_req  = 1'b0;
      row_idx  = 5'd0;
      swap     = 1'b0;
      rd_col   = 4'd0;
      #1;
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_overrun", {31'd0, ovr_o}, 32'd0);
      chk("rst_addr", {20'd0, addr_o}, 32'h00AA);
      chk("rst_color", {29'd0, color_o}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // Test 1: idle CPU, row 3
      fetch_idle(3, 30, 1'b0);
      do_swap();
      readback_vec("t1_color");

      // Test 2: CPU requests every cycle, forced grant every 9th FETCH cycle
      cpu_req  = 1'b1;
      cpu_addr = 12'h123;
      row_req  = 1'b1;
      row_idx  = 5'd7;
      tick();
      row_req  = 1'b0;
      for (int c = 1; c <= 92; c++) begin
         bit fs;
         fs = (c % 9 == 0) && (c <= 90);
         @(negedge clock);
         chk("t2_stall", {31'd0, stall_o}, {31'd0, fs});
         chk("t2_addr", {20'd0, addr_o}, fs ? 32'(70 + c / 9 - 1) : 32'h0123);
         chk("t2_done", {31'd0, done_o}, {31'd0, (c == 92)});
         tick();
      end
      cpu_req = 1'b0;
      do_swap();
      readback_mem("t2_color", 70, 1'b0);

      // Test 3: STARVE_LIMIT=0 instance, alternating CPU requests
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      sel_b   = 1'b1;
      row_req = 1'b1;
      row_idx = 5'd5;
      cpu_req = 1'b0;
      tick();
      row_req = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         cpu_req  = (c % 2 == 1);
         cpu_addr = 12'h200 + 12'(c);
         @(negedge clock);
         chk("t3_stall", {31'd0, stall_o}, 32'd0);
         chk("t3_addr", {20'd0, addr_o},
             (cpu_req || c > 20) ? {20'd0, cpu_addr} : 32'(50 + c / 2 - 1));
         chk("t3_done", {31'd0, done_o}, {31'd0, (c == 22)});
         tick();
      end
      cpu_req = 1'b0;
      do_swap();
      readback_mem("t3_color", 50, 1'b0);

      // Test 4: collisions ignored, overrun sticky, swap in DONE applied
      sel_b = 1'b0;
      @(negedge clock);
      chk("t4_overrun_pre", {31'd0, ovr_o}, 32'd0);
      tick();
      fetch_idle(3, 30, 1'b1);
      readback_vec("t4_color");
      chk("t4_overrun_post", {31'd0, ovr_o}, 32'd1);

      // Test 5: out-of-range row clears the back bank
      cpu_addr = 12'h3AB;
      row_req  = 1'b1;
      row_idx  = 5'd25;
      tick();
      row_req  = 1'b0;
      @(negedge clock);
      chk("t5_busy", {31'd0, busy_o}, 32'd1);
      chk("t5_addr1", {20'd0, addr_o}, 32'h03AB);
      chk("t5_done1", {31'd0, done_o}, 32'd0);
      tick();
      @(negedge clock);
      chk("t5_done2", {31'd0, done_o}, 32'd1);
      chk("t5_addr2", {20'd0, addr_o}, 32'h03AB);
      tick();
      do_swap();
      readback_mem("t5_color", 0, 1'b1);
      chk("t5_overrun", {31'd0, ovr_o}, 32'd1);

      // Test 6: asynchronous reset mid-fetch, then a clean refetch
      cpu_addr = 12'h0FFF;
      row_req  = 1'b1;
      row_idx  = 5'd7;
      tick();
      row_req  = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clock);
         if (c == 6) chk("t6_addr_col5", {20'd0, addr_o}, 32'd75);
         if (c < 6) tick();
      end
      rd_col = 4'd0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_busy", {31'd0, busy_o}, 32'd0);
      chk("t6_done", {31'd0, done_o}, 32'd0);
      chk("t6_overrun", {31'd0, ovr_o}, 32'd0);
      chk("t6_stall", {31'd0, stall_o}, 32'd0);
      chk("t6_addr", {20'd0, addr_o}, 32'h0FFF);
      chk("t6_color", {29'd0, color_o}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      fetch_idle(7, 70, 1'b0);
      do_swap();
      readback_mem("t6_color_refetch", 70, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
